sdram_aref_ctrl: RTL and testbench

SDRAM_AREF_CTRL -- requirements
Module: sdram_aref_ctrl

---
 rtl/sdram_aref_ctrl.sv | 110 +++++++++++
 tb/tb_sdram_aref_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh controller: interval timer, owed-refresh counter and an
// AUTO-REFRESH command sequencer that requests the bus from an arbiter.
module sdram_aref_ctrl #(
   parameter int REF_PERIOD = 780,
   parameter int tRC        = 8,
   parameter int MAX_PEND   = 8
) (
   input  logic        REF_CLK,
   input  logic        RST_N,
   input  logic        init_done,
   input  logic        aref_en,
   output logic        aref_req,
   output logic        aref_done,
   output logic [4:0]  cmd,
   output logic [1:0]  bs,
   output logic [12:0] addr,
   output logic [3:0]  pend_cnt,
   output logic        overflow
);

   localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
   localparam int WW = $clog2(tRC + 1);

   localparam logic [4:0] CMD_NOP = 5'b10111;
   localparam logic [4:0] CMD_AF  = 5'b10001;

   typedef enum logic [1:0] {S_IDLE, S_AF, S_AF_WAIT, S_DONE} state_t;

   state_t         r_state, w_next;
   logic [TW-1:0]  r_timer;
   logic [WW-1:0]  r_wait;
   logic [3:0]     r_pend;
   logic           r_ovf;
   logic [4:0]     r_cmd;
   logic [1:0]     r_bs;
   logic [12:0]    r_addr;
   logic           w_tick, w_in_af, w_wait_end, w_pend_max;

   assign w_tick     = init_done && (r_timer == TW'(REF_PERIOD - 1));
   assign w_in_af    = (r_state == S_AF);
   assign w_wait_end = (r_wait == WW'(tRC));
   assign w_pend_max = (r_pend == 4'(MAX_PEND));

   always_ff @(posedge REF_CLK or negedge RST_N) begin
      if (!RST_N)          r_timer <= '0;
      else if (!init_done) r_timer <= '0;
      else if (w_tick)     r_timer <= '0;
      else                 r_timer <= r_timer + TW'(1);
   end

   // A tick and an AF cycle cancel; losing init_done wipes the debt.
   always_ff @(posedge REF_CLK or negedge RST_N) begin
      if (!RST_N)                                  r_pend <= '0;
      else if (!init_done)                         r_pend <= '0;
      else if (w_tick && !w_in_af) begin
         if (!w_pend_max)                          r_pend <= r_pend + 4'd1;
      end
      else if (!w_tick && w_in_af && r_pend != 0)  r_pend <= r_pend - 4'd1;
   end

   always_ff @(posedge REF_CLK or negedge RST_N) begin
      if (!RST_N)                     r_ovf <= 1'b0;
      else if (w_tick && w_pend_max)  r_ovf <= 1'b1;
   end

   always_ff @(posedge REF_CLK or negedge RST_N) begin
      if (!RST_N)                                      r_wait <= '0;
      else if (r_state == S_AF_WAIT && !w_wait_end)    r_wait <= r_wait + WW'(1);
      else                                             r_wait <= '0;
   end

   always_ff @(posedge REF_CLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (aref_req && aref_en) w_next = S_AF;
         S_AF:      w_next = S_AF_WAIT;
         S_AF_WAIT: if (w_wait_end)
                       w_next = (r_pend != 0 && aref_en && init_done) ? S_AF : S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Command bus is registered from the current state, so it trails by one cycle.
   always_ff @(posedge REF_CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cmd  <= CMD_NOP;
         r_bs   <= 2'b11;
         r_addr <= 13'h1fff;
      end else begin
         r_cmd  <= w_in_af ? CMD_AF : CMD_NOP;
         r_bs   <= 2'b11;
         r_addr <= 13'h1fff;
      end
   end

   assign aref_req  = (r_state == S_IDLE) && (r_pend != 0) && init_done;
   assign aref_done = (r_state == S_DONE);
   assign cmd       = r_cmd;
   assign bs        = r_bs;
   assign addr      = r_addr;
   assign pend_cnt  = r_pend;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Scoreboard bench for sdram_aref_ctrl: expected AF / done cycles are queued
// when stimulus is applied and popped by a monitor as the DUT produces them.
module tb_sdram_aref_ctrl;

   localparam int P   = 780;
   localparam int TRC = 8;
   localparam logic [4:0] NOP = 5'b10111;
   localparam logic [4:0] AF  = 5'b10001;

   logic        REF_CLK = 1'b0;
   logic        RST_N, init_done, aref_en;
   logic        aref_req, aref_done, overflow;
   logic [4:0]  cmd;
   logic [1:0]  bs;
   logic [12:0] addr;
   logic [3:0]  pend_cnt;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int af_q[$];
   int done_q[$];

   sdram_aref_ctrl #(.REF_PERIOD(P), .tRC(TRC), .MAX_PEND(8)) dut (
      .REF_CLK(REF_CLK), .RST_N(RST_N), .init_done(init_done), .aref_en(aref_en),
      .aref_req(aref_req), .aref_done(aref_done), .cmd(cmd), .bs(bs), .addr(addr),
      .pend_cnt(pend_cnt), .overflow(overflow)
   );

   always #5 REF_CLK = ~REF_CLK;
   always @(posedge REF_CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge REF_CLK);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd"},  cmd, NOP);
      chk({tag, "_bs"},   bs, 2'b11);
      chk({tag, "_addr"}, addr, 13'h1fff);
      chk({tag, "_pend"}, pend_cnt, 0);
      chk({tag, "_ovf"},  overflow, 0);
      chk({tag, "_req"},  aref_req, 0);
      chk({tag, "_done"}, aref_done, 0);
   endtask

   // Fresh reset, then enable the block; returns the cycle init_done was raised.
   task automatic start(input logic en, output int c0);
      @(negedge REF_CLK);
      RST_N = 1'b0; init_done = 1'b0; aref_en = 1'b0;
      repeat (2) @(negedge REF_CLK);
      RST_N = 1'b1;
      @(negedge REF_CLK);
      init_done = 1'b1; aref_en = en;
      c0 = cyc;
   endtask

   task automatic check_drained(input string tag);
      chk({tag, "_afq_left"},   af_q.size(), 0);
      chk({tag, "_doneq_left"}, done_q.size(), 0);
   endtask

   // Monitor: every AF command and every done pulse must match a queued expectation.
   always @(negedge REF_CLK) begin
      if (RST_N === 1'b1) begin
         if (cmd == AF) begin
            if (af_q.size() == 0) chk("af_unexpected_qsize", 0, 1);
            else begin
               chk("af_cycle", cyc, af_q.pop_front());
               chk("af_bs", bs, 2'b11);
               chk("af_addr", addr, 13'h1fff);
            end
         end else if (cmd != NOP) chk("cmd_enc", cmd, NOP);
         if (aref_done) begin
            if (done_q.size() == 0) chk("done_unexpected_qsize", 0, 1);
            else chk("done_cycle", cyc, done_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0, g, r;
      RST_N = 1'b0; init_done = 1'b0; aref_en = 1'b0;
      repeat (3) @(negedge REF_CLK);
      check_reset_vals("rst");

      // single refresh with grant held high
      start(1'b1, c0);
      g = c0 + P + 1;
      af_q.push_back(g + 1); done_q.push_back(g + 10);
      wait_to(c0 + P - 1); chk("s1_req_early", aref_req, 0);
      wait_to(c0 + P);     chk("s1_req_rise", aref_req, 1); chk("s1_pend1", pend_cnt, 1);
      wait_to(g + 15);     chk("s1_pend0", pend_cnt, 0); check_drained("s1");

      // three owed refreshes drained as one burst
      start(1'b0, c0);
      wait_to(c0 + 3 * P); chk("s2_pend3", pend_cnt, 3);
      aref_en = 1'b1; g = c0 + 3 * P + 1;
      for (int i = 0; i < 3; i++) af_q.push_back(g + 1 + 10 * i);
      done_q.push_back(g + 30);
      wait_to(g + 35); chk("s2_pend0", pend_cnt, 0); check_drained("s2");

      // saturation and sticky overflow
      start(1'b0, c0);
      wait_to(c0 + 8 * P); chk("s3_pend8", pend_cnt, 8); chk("s3_ovf0", overflow, 0);
      wait_to(c0 + 9 * P); chk("s3_pend_sat", pend_cnt, 8); chk("s3_ovf1", overflow, 1);
      aref_en = 1'b1; g = c0 + 9 * P + 1;
      for (int i = 0; i < 8; i++) af_q.push_back(g + 1 + 10 * i);
      done_q.push_back(g + 80);
      wait_to(g + 85);
      chk("s3_pend0", pend_cnt, 0); chk("s3_ovf_sticky", overflow, 1); check_drained("s3");

      // tick coincides with the AF cycle
      start(1'b0, c0);
      wait_to(c0 + 2 * P - 2); chk("s4_pend1", pend_cnt, 1);
      aref_en = 1'b1; g = c0 + 2 * P - 1;
      af_q.push_back(g + 1); af_q.push_back(g + 11); done_q.push_back(g + 20);
      wait_to(g + 1);  chk("s4_pend_hold", pend_cnt, 1);
      wait_to(g + 25); chk("s4_pend0", pend_cnt, 0); check_drained("s4");

      // init_done dropped during AF_WAIT
      start(1'b0, c0);
      wait_to(c0 + 2 * P); chk("s5_pend2", pend_cnt, 2);
      aref_en = 1'b1; g = c0 + 2 * P + 1;
      af_q.push_back(g + 1); done_q.push_back(g + 10);
      wait_to(g + 4); init_done = 1'b0;
      wait_to(g + 40);
      chk("s5_pend0", pend_cnt, 0); chk("s5_req0", aref_req, 0); check_drained("s5");

      // asynchronous reset while the AF command is on the bus
      start(1'b0, c0);
      wait_to(c0 + 2 * P);
      aref_en = 1'b1; g = c0 + 2 * P + 1;
      af_q.push_back(g + 1);
      wait_to(g + 1);
      #2 RST_N = 1'b0;
      #1 check_reset_vals("s6_async");
      @(negedge REF_CLK); @(negedge REF_CLK);
      check_drained("s6_pre");
      RST_N = 1'b1; r = cyc;
      af_q.push_back(r + P + 2); done_q.push_back(r + P + 11);
      wait_to(r + P); chk("s6_req_restart", aref_req, 1);
      wait_to(r + P + 15); chk("s6_pend0", pend_cnt, 0); check_drained("s6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
